pkt_tx_arb: RTL and testbench

PKT_TX_ARB -- requirements
Module: pkt_tx_arb

---
 rtl/pkt_tx_arb_if.sv | 31 +++
 rtl/pkt_tx_arb.sv | 195 +++++++++++++++++++
 tb/tb_pkt_tx_arb.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/pkt_tx_arb_if.sv
// Streaming bundle for pkt_tx_arb: per-channel source side plus the MAC transmit side.
// master = arbiter view, slave = channel sources / MAC view.
interface pkt_tx_arb_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 64,
    parameter int MOD_W  = $clog2(DATA_W/8)
);
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [NUM_CH-1:0]        ch_sop;
    logic [NUM_CH-1:0]        ch_eop;
    logic [NUM_CH-1:0]        ch_val;
    logic [NUM_CH*MOD_W-1:0]  ch_mod;
    logic [NUM_CH-1:0]        ch_full;

    logic [DATA_W-1:0]        pkt_tx_data;
    logic                     pkt_tx_sop;
    logic                     pkt_tx_eop;
    logic                     pkt_tx_val;
    logic [MOD_W-1:0]         pkt_tx_mod;
    logic                     pkt_tx_full;

    modport master (
        input  ch_data, ch_sop, ch_eop, ch_val, ch_mod, pkt_tx_full,
        output ch_full, pkt_tx_data, pkt_tx_sop, pkt_tx_eop, pkt_tx_val, pkt_tx_mod
    );

    modport slave (
        output ch_data, ch_sop, ch_eop, ch_val, ch_mod, pkt_tx_full,
        input  ch_full, pkt_tx_data, pkt_tx_sop, pkt_tx_eop, pkt_tx_val, pkt_tx_mod
    );
endinterface

// File: rtl/pkt_tx_arb.sv
// Round-robin packet arbiter: merges NUM_CH packet sources onto one MAC transmit stream, 1-cycle latency.
// Define PKT_TX_ARB_ERR_EN to compile in the protocol checker (err_cnt / err_ch outputs).
module pkt_tx_arb #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 64,
    parameter int MOD_W  = $clog2(DATA_W/8)
) (
    input  logic         clk_156m25,
    input  logic         reset_156m25,
    pkt_tx_arb_if.master bus
`ifdef PKT_TX_ARB_ERR_EN
    ,
    output logic [15:0]       err_cnt,
    output logic [NUM_CH-1:0] err_ch
`endif
);
    localparam int CH_W = $clog2(NUM_CH);

    typedef enum logic {
        IDLE,
        PKT
    } state_e;

    state_e            state_q, state_d;
    logic [CH_W-1:0]   gnt_q, gnt_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_sop_q, tx_sop_d;
    logic              tx_eop_q, tx_eop_d;
    logic              tx_val_q, tx_val_d;
    logic [MOD_W-1:0]  tx_mod_q, tx_mod_d;

    logic [NUM_CH-1:0] ch_full;
    logic [NUM_CH-1:0] acc;
    logic              sel_vld;
    logic [CH_W-1:0]   sel;
    logic [CH_W:0]     sel_sum;
    logic              fwd;
    logic [CH_W-1:0]   fwd_ch;

`ifdef PKT_TX_ARB_ERR_EN
    logic [NUM_CH-1:0] err_hit;
    logic [16:0]       err_sum;
    logic [15:0]       err_cnt_q, err_cnt_d;
    logic [NUM_CH-1:0] err_ch_q, err_ch_d;
`endif

    function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c);
        return (c == CH_W'(NUM_CH - 1)) ? '0 : c + CH_W'(1);
    endfunction

    // First sop requester at or after rr_ptr, wrapping modulo NUM_CH.
    always_comb begin
        sel_vld = 1'b0;
        sel     = '0;
        sel_sum = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            sel_sum = {1'b0, rr_ptr_q} + (CH_W+1)'(k);
            if (sel_sum >= (CH_W+1)'(NUM_CH)) begin
                sel_sum = sel_sum - (CH_W+1)'(NUM_CH);
            end
            if (!sel_vld && bus.ch_val[sel_sum[CH_W-1:0]] && bus.ch_sop[sel_sum[CH_W-1:0]]) begin
                sel_vld = 1'b1;
                sel     = sel_sum[CH_W-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        rr_ptr_d  = rr_ptr_q;
        ch_full   = '1;
        acc       = '0;
        fwd       = 1'b0;
        fwd_ch    = sel;
        tx_val_d  = 1'b0;
        tx_sop_d  = 1'b0;
        tx_eop_d  = 1'b0;
        tx_mod_d  = '0;
        tx_data_d = '0;
`ifdef PKT_TX_ARB_ERR_EN
        err_hit   = '0;
`endif

        // In IDLE, non-sop words are let through so a stray source cannot block arbitration.
        if (!reset_156m25 && !bus.pkt_tx_full) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (state_q == PKT) begin
                    ch_full[k] = (CH_W'(k) != gnt_q);
                end else begin
                    ch_full[k] = !((sel_vld && (CH_W'(k) == sel)) ||
                                   (bus.ch_val[k] && !bus.ch_sop[k]));
                end
            end
        end
        acc = bus.ch_val & ~ch_full;

        if (state_q == IDLE) begin
            if (sel_vld && acc[sel]) begin
                fwd    = 1'b1;
                fwd_ch = sel;
                if (bus.ch_eop[sel]) begin
                    rr_ptr_d = next_ch(sel);
                end else begin
                    state_d = PKT;
                    gnt_d   = sel;
                end
            end
`ifdef PKT_TX_ARB_ERR_EN
            err_hit = acc & ~bus.ch_sop;
`endif
        end else if (acc[gnt_q]) begin
            fwd    = 1'b1;
            fwd_ch = gnt_q;
            if (bus.ch_eop[gnt_q]) begin
                state_d  = IDLE;
                rr_ptr_d = next_ch(gnt_q);
            end
`ifdef PKT_TX_ARB_ERR_EN
            err_hit[gnt_q] = bus.ch_sop[gnt_q];
`endif
        end

        if (fwd) begin
            tx_val_d  = 1'b1;
            tx_data_d = bus.ch_data[fwd_ch*DATA_W +: DATA_W];
            tx_sop_d  = bus.ch_sop[fwd_ch];
            tx_eop_d  = bus.ch_eop[fwd_ch];
            if (tx_eop_d) begin
                tx_mod_d = bus.ch_mod[fwd_ch*MOD_W +: MOD_W];
            end
`ifdef PKT_TX_ARB_ERR_EN
            // A sop inside a granted packet is a protocol error; suppress it to keep framing intact.
            if (state_q == PKT) begin
                tx_sop_d = 1'b0;
            end
`endif
        end
    end

`ifdef PKT_TX_ARB_ERR_EN
    always_comb begin
        err_sum = {1'b0, err_cnt_q};
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            err_sum = err_sum + 17'(err_hit[k]);
        end
        err_cnt_d = err_sum[16] ? '1 : err_sum[15:0];
        err_ch_d  = err_ch_q | err_hit;
    end
`endif

    always_ff @(posedge clk_156m25) begin
        if (reset_156m25) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            rr_ptr_q  <= '0;
            tx_data_q <= '0;
            tx_sop_q  <= 1'b0;
            tx_eop_q  <= 1'b0;
            tx_val_q  <= 1'b0;
            tx_mod_q  <= '0;
`ifdef PKT_TX_ARB_ERR_EN
            err_cnt_q <= '0;
            err_ch_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            rr_ptr_q  <= rr_ptr_d;
            tx_data_q <= tx_data_d;
            tx_sop_q  <= tx_sop_d;
            tx_eop_q  <= tx_eop_d;
            tx_val_q  <= tx_val_d;
            tx_mod_q  <= tx_mod_d;
`ifdef PKT_TX_ARB_ERR_EN
            err_cnt_q <= err_cnt_d;
            err_ch_q  <= err_ch_d;
`endif
        end
    end

    assign bus.ch_full     = ch_full;
    assign bus.pkt_tx_data = tx_data_q;
    assign bus.pkt_tx_sop  = tx_sop_q;
    assign bus.pkt_tx_eop  = tx_eop_q;
    assign bus.pkt_tx_val  = tx_val_q;
    assign bus.pkt_tx_mod  = tx_mod_q;

`ifdef PKT_TX_ARB_ERR_EN
    assign err_cnt = err_cnt_q;
    assign err_ch  = err_ch_q;
`endif
endmodule

// File: tb/tb_pkt_tx_arb.sv
// Directed self-checking bench for pkt_tx_arb (NUM_CH=4, DATA_W=64); expectations are hand-derived.
module tb_pkt_tx_arb;
    localparam int NUM_CH = 4;
    localparam int DATA_W = 64;
    localparam int MOD_W  = 3;

    logic clk_156m25 = 1'b0;
    logic reset_156m25;

    always #5 clk_156m25 = ~clk_156m25;

    pkt_tx_arb_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .MOD_W(MOD_W)) bus ();

`ifdef PKT_TX_ARB_ERR_EN
    logic [15:0]       err_cnt;
    logic [NUM_CH-1:0] err_ch;
`endif

    pkt_tx_arb #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .MOD_W(MOD_W)) dut (
        .clk_156m25   (clk_156m25),
        .reset_156m25 (reset_156m25),
        .bus          (bus)
`ifdef PKT_TX_ARB_ERR_EN
        ,
        .err_cnt      (err_cnt),
        .err_ch       (err_ch)
`endif
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] w(input int c, input int n);
        return 64'hC0DE_0000_0000_0000 | (64'(c) << 8) | 64'(n);
    endfunction

    task automatic drive(input int c, input logic val, input logic sop, input logic eop,
                         input logic [63:0] data, input logic [2:0] mod);
        bus.ch_val[c] = val;
        bus.ch_sop[c] = sop;
        bus.ch_eop[c] = eop;
        bus.ch_data[c*DATA_W +: DATA_W] = data;
        bus.ch_mod[c*MOD_W +: MOD_W] = mod;
    endtask

    task automatic clear_all();
        bus.ch_val  = '0;
        bus.ch_sop  = '0;
        bus.ch_eop  = '0;
        bus.ch_data = '0;
        bus.ch_mod  = '0;
    endtask

    task automatic tick();
        @(posedge clk_156m25);
        #1;
    endtask

    task automatic full_is(input string tag, input logic [3:0] exp);
        #1;
        chk(tag, 128'(bus.ch_full), 128'(exp));
    endtask

    task automatic out_is(input string tag, input logic v, input logic s, input logic e,
                          input logic [2:0] m, input logic [63:0] d);
        chk(tag,
            {58'd0, bus.pkt_tx_val, bus.pkt_tx_sop, bus.pkt_tx_eop, bus.pkt_tx_mod, bus.pkt_tx_data},
            {58'd0, v, s, e, m, d});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_156m25    = 1'b1;
        bus.pkt_tx_full = 1'b0;
        clear_all();
        drive(0, 1, 1, 0, w(0, 0), 0);
        tick();
        full_is("rst_full", 4'b1111);
        tick();
        out_is("rst_out", 0, 0, 0, 0, 64'd0);
        reset_156m25 = 1'b0;

        // ch0 and ch2 start together; ch0 wins, ch2 follows back to back
        drive(0, 1, 1, 0, w(0, 0), 0);
        drive(2, 1, 1, 0, w(2, 0), 0);
        full_is("two_sop_full", 4'b1110);
        tick();
        out_is("c0w0", 1, 1, 0, 0, w(0, 0));
        drive(0, 1, 0, 0, w(0, 1), 0);
        full_is("c0_pkt_full", 4'b1110);
        tick();
        out_is("c0w1", 1, 0, 0, 0, w(0, 1));
        drive(0, 1, 0, 1, w(0, 2), 0);
        full_is("c0_eop_full", 4'b1110);
        tick();
        out_is("c0w2", 1, 0, 1, 0, w(0, 2));
        drive(0, 0, 0, 0, 64'd0, 0);
        full_is("c2_sel_full", 4'b1011);
        tick();
        out_is("c2w0", 1, 1, 0, 0, w(2, 0));
        drive(2, 1, 0, 0, w(2, 1), 0);
        full_is("c2_pkt_full", 4'b1011);
        tick();
        out_is("c2w1", 1, 0, 0, 0, w(2, 1));
        drive(2, 1, 0, 1, w(2, 2), 3);
        tick();
        out_is("c2w2_mod3", 1, 0, 1, 3, w(2, 2));
        drive(2, 0, 0, 0, 64'd0, 0);
        tick();
        out_is("idle_after_c2", 0, 0, 0, 0, 64'd0);

        // reset to zero rr_ptr, then all channels stream single-word packets
        reset_156m25 = 1'b1;
        tick();
        reset_156m25 = 1'b0;
        for (int k = 0; k < NUM_CH; k++) drive(k, 1, 1, 1, w(k, 9), 0);
        for (int n = 0; n < 5; n++) begin
            full_is("rr_full", 4'(~(4'b0001 << (n % 4))));
            tick();
            out_is("rr_out", 1, 1, 1, 0, w(n % 4, 9));
        end
        clear_all();

        // ch1 packet: grant hold on val gap, then 5 cycles of MAC backpressure
        drive(1, 1, 1, 0, w(1, 0), 0);
        full_is("c1_sel_full", 4'b1101);
        tick();
        out_is("c1w0", 1, 1, 0, 0, w(1, 0));
        drive(1, 0, 0, 0, 64'd0, 0);
        drive(2, 1, 1, 0, w(2, 0), 0);
        full_is("gnt_hold_full", 4'b1101);
        tick();
        out_is("gnt_hold_out", 0, 0, 0, 0, 64'd0);
        drive(2, 0, 0, 0, 64'd0, 0);
        drive(1, 1, 0, 0, w(1, 1), 0);
        tick();
        out_is("c1w1", 1, 0, 0, 0, w(1, 1));
        drive(1, 1, 0, 0, w(1, 2), 0);
        bus.pkt_tx_full = 1'b1;
        for (int n = 0; n < 5; n++) begin
            full_is("bp_full", 4'b1111);
            tick();
            out_is("bp_out", 0, 0, 0, 0, 64'd0);
        end
        bus.pkt_tx_full = 1'b0;
        full_is("bp_release_full", 4'b1101);
        tick();
        out_is("c1w2", 1, 0, 0, 0, w(1, 2));
        drive(1, 1, 0, 1, w(1, 3), 5);
        tick();
        out_is("c1w3", 1, 0, 1, 5, w(1, 3));
        clear_all();
        tick();
        out_is("idle_after_c1", 0, 0, 0, 0, 64'd0);

        // stray non-sop word in IDLE is swallowed
        drive(1, 1, 0, 0, w(1, 7), 0);
        full_is("discard_full", 4'b1101);
        tick();
        out_is("discard_out", 0, 0, 0, 0, 64'd0);
`ifdef PKT_TX_ARB_ERR_EN
        chk("err_cnt", 128'(err_cnt), 128'd1);
        chk("err_ch", 128'(err_ch), 128'b0010);
`endif
        clear_all();

        // reset during ch3 word 2, then ch0 beats the ch3 retry
        drive(3, 1, 1, 0, w(3, 0), 0);
        full_is("c3_sel_full", 4'b0111);
        tick();
        out_is("c3w0", 1, 1, 0, 0, w(3, 0));
        drive(3, 1, 0, 0, w(3, 1), 0);
        reset_156m25 = 1'b1;
        full_is("rst_mid_full", 4'b1111);
        tick();
        out_is("rst_mid_out", 0, 0, 0, 0, 64'd0);
        reset_156m25 = 1'b0;
        drive(3, 1, 1, 0, w(3, 0), 0);
        drive(0, 1, 1, 1, w(0, 5), 0);
        full_is("post_rst_full", 4'b1110);
        tick();
        out_is("post_rst_c0", 1, 1, 1, 0, w(0, 5));
        drive(0, 0, 0, 0, 64'd0, 0);
        full_is("retry_full", 4'b0111);
        tick();
        out_is("retry_c3w0", 1, 1, 0, 0, w(3, 0));
        drive(3, 1, 0, 1, w(3, 1), 0);
        tick();
        out_is("retry_c3w1", 1, 0, 1, 0, w(3, 1));
        clear_all();
        tick();
        out_is("final_idle", 0, 0, 0, 0, 64'd0);
`ifdef PKT_TX_ARB_ERR_EN
        chk("err_cnt_cleared", 128'(err_cnt), 128'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
